hazard_ctrl_mc: RTL and testbench

Parametrised pipeline hazard/segment controller, successor to the single-cycle load-use/branch unit. Sits beside the IF/ID/EX/MEM segment registers and drives their stall/flush enables. Adds:
- configurable load-use latency, with a multi-bubble counter
- an N-read-port ID stage
- a multi-cycle MDU busy handshake with watchdog
- a global external freeze
- saturating performance counters

---
 rtl/hazard_pkg.sv | 7 +
 rtl/hazard_ctrl_mc_match.sv | 21 ++
 rtl/hazard_ctrl_mc.sv | 127 ++++++++++++
 tb/tb_hazard_ctrl_mc.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM states and encodings for the pipeline hazard controller.
package hazard_pkg;
    typedef enum logic [1:0] {RUN, LOAD_WAIT, MDU_BUSY} state_e;
    localparam logic [1:0] WD_SEL_LOAD = 2'b10;
    localparam logic [1:0] NPC_SEL_BR  = 2'b01;
    localparam logic [1:0] NPC_SEL_JMP = 2'b10;
endpackage

// File: rtl/hazard_ctrl_mc_match.sv
// hazard_match: load-use detector comparing an EX load destination against NRP ID read ports.
module hazard_match
    import hazard_pkg::*;
#(
    parameter int AW  = 5,
    parameter int NRP = 2
) (
    input  logic              we_i,
    input  logic [1:0]        wd_sel_i,
    input  logic [AW-1:0]     wa_i,
    input  logic [NRP*AW-1:0] ra_i,
    input  logic [NRP-1:0]    re_i,
    output logic              lu_o
);
    logic hit;
    always_comb begin
        hit = 1'b0;
        for (int k = 0; k < NRP; k++) hit = hit | (re_i[k] & (ra_i[k*AW +: AW] == wa_i));
    end
    assign lu_o = we_i & (wd_sel_i == WD_SEL_LOAD) & (wa_i != '0) & hit;
endmodule

// File: rtl/hazard_ctrl_mc.sv
// hazard_ctrl_mc: stall/flush controller for IF/ID/EX/MEM with multi-bubble load-use,
// MDU busy handshake with watchdog, external freeze and saturating perf counters.
module hazard_ctrl_mc
    import hazard_pkg::*;
#(
    parameter int AW       = 5,
    parameter int NRP      = 2,
    parameter int LOAD_LAT = 1,
    parameter int MDU_MAX  = 64,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ext_stall,
    input  logic              rf_we_ex,
    input  logic [1:0]        rf_wd_sel_ex,
    input  logic [AW-1:0]     rf_wa_ex,
    input  logic [NRP*AW-1:0] rf_ra_id,
    input  logic [NRP-1:0]    rf_re_id,
    input  logic [1:0]        npc_sel_ex,
    input  logic              mdu_start_ex,
    input  logic              mdu_done,
    output logic              stall_pc,
    output logic              stall_if_id,
    output logic              stall_id_ex,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic              flush_ex_mem,
    output logic              mdu_err,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);
    localparam int BW = $clog2(LOAD_LAT + 1);
    localparam int TW = $clog2(MDU_MAX + 1);

    state_e           state_q, state_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] scnt_q, fcnt_q;
    logic             lu, br, br_hit;
    logic             s_pc, s_ifid, s_idex, f_ifid, f_idex, f_exmem;

    hazard_match #(.AW(AW), .NRP(NRP)) u_match (
        .we_i     (rf_we_ex),
        .wd_sel_i (rf_wd_sel_ex),
        .wa_i     (rf_wa_ex),
        .ra_i     (rf_ra_id),
        .re_i     (rf_re_id),
        .lu_o     (lu)
    );

    assign br = (npc_sel_ex == NPC_SEL_BR) | (npc_sel_ex == NPC_SEL_JMP);

    always_comb begin
        {s_pc, s_ifid, s_idex, f_ifid, f_idex, f_exmem} = '0;
        state_d = state_q;
        bcnt_d  = bcnt_q;
        timer_d = timer_q;
        err_d   = err_q;
        br_hit  = 1'b0;
        if (ext_stall) {s_pc, s_ifid, s_idex} = '1;
        else case (state_q)
            RUN: begin
                if (lu) begin
                    {s_pc, s_ifid, f_idex} = '1;
                    if (LOAD_LAT > 1) begin
                        state_d = LOAD_WAIT;
                        bcnt_d  = BW'(LOAD_LAT - 1);
                    end
                end else if (mdu_start_ex) begin
                    {s_pc, s_ifid, s_idex, f_exmem} = '1;
                    state_d = MDU_BUSY;
                    timer_d = TW'(1);
                end else if (br) begin
                    {f_ifid, f_idex} = '1;
                    br_hit = 1'b1;
                end
            end
            LOAD_WAIT: begin
                {s_pc, s_ifid, f_idex} = '1;
                bcnt_d = bcnt_q - BW'(1);
                if (bcnt_q == BW'(1)) state_d = RUN;
            end
            MDU_BUSY: begin
                // done beats the watchdog when both land on the same cycle
                if (mdu_done) state_d = RUN;
                else if (timer_q == TW'(MDU_MAX)) begin
                    err_d   = 1'b1;
                    state_d = RUN;
                end else begin
                    {s_pc, s_ifid, s_idex, f_exmem} = '1;
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= RUN;
            bcnt_q  <= '0;
            timer_q <= '0;
            err_q   <= 1'b0;
            scnt_q  <= '0;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            timer_q <= timer_d;
            err_q   <= err_d;
            if (s_pc && !(&scnt_q)) scnt_q <= scnt_q + CNT_W'(1);
            if (br_hit && !(&fcnt_q)) fcnt_q <= fcnt_q + CNT_W'(1);
        end
    end

    assign stall_pc     = s_pc & ~rst;
    assign stall_if_id  = s_ifid & ~rst;
    assign stall_id_ex  = s_idex & ~rst;
    assign flush_if_id  = f_ifid & ~rst;
    assign flush_id_ex  = f_idex & ~rst;
    assign flush_ex_mem = f_exmem & ~rst;
    assign mdu_err      = err_q;
    assign stall_cnt    = scnt_q;
    assign flush_cnt    = fcnt_q;
endmodule

// File: tb/tb_hazard_ctrl_mc.sv
// tb_hazard_ctrl_mc: runs a LOAD_LAT=1 and a LOAD_LAT=3 instance side by side against a
// cycle-level model of bubbles-remaining / MDU-age, plus hand-computed spot values.
module tb_hazard_ctrl_mc;
    localparam int AW = 5;
    localparam int NRP = 2;
    localparam int MM = 8;

    logic clk = 1'b0;
    logic rst, ext, we, start, done;
    logic [1:0] wd, npc, re;
    logic [AW-1:0] wa;
    logic [NRP*AW-1:0] ra;

    logic [5:0]  ctl [2];
    logic        err [2];
    logic [15:0] sc [2];
    logic [15:0] fc [2];

    int pass_n = 0;
    int total_n = 0;

    int  rem [2];
    int  age [2];
    bit  busy [2];
    bit  merr [2];
    int  scnt [2];
    int  fcnt [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : gi
        localparam int CW = (g == 0) ? 16 : 6;
        logic [CW-1:0] scw, fcw;
        logic sp, sif, sie, fif, fie, fem, er;
        hazard_ctrl_mc #(.AW(AW), .NRP(NRP), .LOAD_LAT(g == 0 ? 1 : 3), .MDU_MAX(MM), .CNT_W(CW)) dut (
            .clk(clk), .rst(rst), .ext_stall(ext), .rf_we_ex(we), .rf_wd_sel_ex(wd),
            .rf_wa_ex(wa), .rf_ra_id(ra), .rf_re_id(re), .npc_sel_ex(npc),
            .mdu_start_ex(start), .mdu_done(done),
            .stall_pc(sp), .stall_if_id(sif), .stall_id_ex(sie), .flush_if_id(fif),
            .flush_id_ex(fie), .flush_ex_mem(fem), .mdu_err(er),
            .stall_cnt(scw), .flush_cnt(fcw)
        );
        assign ctl[g] = {sp, sif, sie, fif, fie, fem};
        assign err[g] = er;
        assign sc[g]  = 16'(scw);
        assign fc[g]  = 16'(fcw);
    end

    function automatic int lat_of(int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int cmax_of(int i);
        return (i == 0) ? 65535 : 63;
    endfunction

    function automatic bit hz();
        bit h = 0;
        for (int k = 0; k < NRP; k++) if (re[k] && ra[k*AW +: AW] == wa) h = 1;
        return we && wd == 2'b10 && wa != 0 && h;
    endfunction

    function automatic logic [5:0] expect_ctl(int i);
        if (rst) return 6'b000000;
        if (ext) return 6'b111000;
        if (rem[i] > 0) return 6'b110010;
        if (busy[i]) return (done || age[i] == MM) ? 6'b000000 : 6'b111001;
        if (hz()) return 6'b110010;
        if (start) return 6'b111001;
        if (npc == 2'b01 || npc == 2'b10) return 6'b000110;
        return 6'b000000;
    endfunction

    task automatic chk(string nm, int act, int exp);
        total_n++;
        if (act == exp) pass_n++;
        else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    endtask

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                rem[i] = 0; age[i] = 0; busy[i] = 0; merr[i] = 0; scnt[i] = 0; fcnt[i] = 0;
            end else begin
                logic [5:0] e;
                e = expect_ctl(i);
                if (e[5] && scnt[i] < cmax_of(i)) scnt[i]++;
                if (!ext) begin
                    if (rem[i] > 0) rem[i]--;
                    else if (busy[i]) begin
                        if (done) busy[i] = 0;
                        else if (age[i] == MM) begin merr[i] = 1; busy[i] = 0; end
                        else age[i]++;
                    end
                    else if (hz()) rem[i] = lat_of(i) - 1;
                    else if (start) begin busy[i] = 1; age[i] = 1; end
                    else if ((npc == 2'b01 || npc == 2'b10) && fcnt[i] < cmax_of(i)) fcnt[i]++;
                end
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ctl%0d", i), int'(ctl[i]), int'(expect_ctl(i)));
            chk($sformatf("err%0d", i), int'(err[i]), int'(merr[i]));
            chk($sformatf("scnt%0d", i), int'(sc[i]), scnt[i]);
            chk($sformatf("fcnt%0d", i), int'(fc[i]), fcnt[i]);
        end
    end

    task automatic idle();
        ext = 0; we = 0; wd = 0; wa = 0; ra = 0; re = 0; npc = 0; start = 0; done = 0;
    endtask

    task automatic cyc(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_x5();
        idle(); we = 1; wd = 2'b10; wa = 5; ra = {5'd5, 5'd3}; re = 2'b11;
    endtask

    initial begin
        rst = 1; idle();
        cyc(2);
        chk("rst_ctl0", int'(ctl[0]), 0);
        chk("rst_ctl1", int'(ctl[1]), 0);
        rst = 0;
        // load-use on port1
        load_x5(); #1;
        chk("lu_first0", int'(ctl[0]), 6'b110010);
        chk("lu_first1", int'(ctl[1]), 6'b110010);
        cyc(1);
        idle(); npc = 2'b01; #1;
        chk("br_in_lw", int'(ctl[1]), 6'b110010);
        chk("br_run", int'(ctl[0]), 6'b000110);
        cyc(1);
        idle(); cyc(2);
        chk("lu_scnt_lat1", int'(sc[0]), 1);
        chk("lu_scnt_lat3", int'(sc[1]), 3);
        chk("br_fcnt_lat1", int'(fc[0]), 1);
        chk("br_fcnt_lat3", int'(fc[1]), 0);
        // x0 destination, disabled port, non-load writer
        we = 1; wd = 2'b10; wa = 0; ra = 0; re = 2'b11; #1;
        chk("x0_0", int'(ctl[0]), 0);
        chk("x0_1", int'(ctl[1]), 0);
        cyc(1);
        wa = 7; ra = {5'd1, 5'd7}; re = 2'b10; #1;
        chk("re_off", int'(ctl[1]), 0);
        cyc(1);
        wd = 2'b00; ra = {5'd7, 5'd7}; re = 2'b11; #1;
        chk("non_load", int'(ctl[1]), 0);
        cyc(1);
        // freeze in the middle of a multi-bubble hazard
        load_x5(); cyc(1);
        idle(); ext = 1; #1;
        chk("ext_ctl", int'(ctl[1]), 6'b111000);
        cyc(4);
        ext = 0; #1;
        chk("resume_lw", int'(ctl[1]), 6'b110010);
        chk("resume_run", int'(ctl[0]), 0);
        cyc(2);
        chk("lw_done", int'(ctl[1]), 0);
        chk("ext_scnt0", int'(sc[0]), 6);
        chk("ext_scnt1", int'(sc[1]), 10);
        // MDU op finishing on the 6th cycle
        idle(); start = 1; #1;
        chk("mdu_start", int'(ctl[0]), 6'b111001);
        cyc(1);
        start = 0; cyc(4);
        done = 1; #1;
        chk("mdu_done0", int'(ctl[0]), 0);
        chk("mdu_done1", int'(ctl[1]), 0);
        cyc(1);
        done = 0;
        chk("mdu_noerr", int'(err[0]), 0);
        // watchdog expiry
        start = 1; cyc(1);
        start = 0; cyc(7); #1;
        chk("wd_out0", int'(ctl[0]), 0);
        chk("wd_pre_err", int'(err[0]), 0);
        cyc(1);
        chk("wd_err0", int'(err[0]), 1);
        chk("wd_err1", int'(err[1]), 1);
        npc = 2'b10; cyc(3);
        load_x5(); cyc(1);
        idle(); cyc(3);
        chk("err_sticky", int'(err[1]), 1);
        // async reset in the middle of an MDU op
        start = 1; cyc(1);
        start = 0; cyc(2);
        #2 rst = 1;
        #1;
        chk("arst_ctl0", int'(ctl[0]), 0);
        chk("arst_ctl1", int'(ctl[1]), 0);
        chk("arst_err", int'(err[0]), 0);
        chk("arst_scnt", int'(sc[0]), 0);
        chk("arst_fcnt", int'(fc[0]), 0);
        @(posedge clk); #2 rst = 0;
        cyc(1);
        chk("post_rst_ctl", int'(ctl[0]), 0);
        chk("post_rst_scnt", int'(sc[1]), 0);
        // counter saturation on the 6-bit instance
        ext = 1; cyc(70);
        ext = 0; npc = 2'b01; cyc(70);
        npc = 0; #1;
        chk("sat_scnt1", int'(sc[1]), 63);
        chk("sat_fcnt1", int'(fc[1]), 63);
        chk("wide_scnt0", int'(sc[0]), 70);
        chk("wide_fcnt0", int'(fc[0]), 70);
        cyc(2);
        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
